// File: rtl/req_sched_pkg.sv
// rtl/req_sched_pkg.sv - shared widths and output-register state type for the request queue scheduler
//
// Purpose: width helpers for queue ids and occupancy counters, and the state
// type of the downstream output register.
// Ports: none (package).

package req_sched_pkg;

  // Bits needed to name one of n queues. A single queue still needs a 1-bit id.
  function automatic int QID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy counter width. One bit wider than the address so that a full
  // queue (count == depth) is representable.
  function automatic int CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/req_queue_scheduler_rr_arbiter.sv
// rtl/req_queue_scheduler_rr_arbiter.sv - round-robin (or strict-priority) grant over non-empty queues
//
// Purpose: picks one requesting queue per cycle. The default search starts
// one past the previously granted queue and wraps. With
// REQ_SCHED_STRICT_PRIO_EN defined, the lowest-index requester always wins
// and last is ignored.
// Ports:
//   req       in   NUM_Q  request vector, one bit per queue
//   last      in   QW     index of the previously granted queue
//   gnt       out  NUM_Q  one-hot grant (zero when nothing requests)
//   gnt_idx   out  QW     index of the granted queue
//   gnt_valid out  1      some queue was granted

module rr_arbiter
  import req_sched_pkg::*;
#(
  parameter int NUM_Q = 4,
  parameter int QW    = QID_W(NUM_Q)
) (
  input  logic [NUM_Q-1:0] req,
  input  logic [QW-1:0]    last,
  output logic [NUM_Q-1:0] gnt,
  output logic [QW-1:0]    gnt_idx,
  output logic             gnt_valid
);

  always_comb begin
    int idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
`ifdef REQ_SCHED_STRICT_PRIO_EN
    // Walk from the top down so the lowest requesting index is written last.
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_idx   = QW'(i);
        gnt_valid = 1'b1;
      end
    end
`else
    // Walk offsets from farthest to nearest so the queue closest after last
    // is the one that sticks.
    for (int k = NUM_Q; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_Q;
      if (req[idx]) begin
        gnt_idx   = QW'(idx);
        gnt_valid = 1'b1;
      end
    end
`endif
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/req_queue_scheduler.sv
// rtl/req_queue_scheduler.sv - dual-port request steering, occupancy tracking and round-robin drain
//
// Purpose: accepts up to two requests per cycle onto a bank of dual-write
// queues, tracks per-queue occupancy to back-pressure requesters, and drains
// one entry per cycle into a registered downstream port.
// Build option: REQ_SCHED_STRICT_PRIO_EN selects fixed lowest-index priority
// instead of round-robin in the drain arbiter.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in0_*/in1_*               request valid/qid/data in, ready out (port 0 older)
//   q_wen1, q_wen2            per-queue first/second write-slot enables
//   q_din1, q_din2            shared write data (in0_data / in1_data)
//   q_ren                     per-queue pop, one-hot or zero
//   q_dout                    queue heads, queue i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/qid/data/ready  registered downstream port
//   q_count                   per-queue occupancy, packed

module req_queue_scheduler
  import req_sched_pkg::*;
#(
  parameter int NUM_Q      = 4,
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in0_valid,
  input  logic [$clog2(NUM_Q)-1:0]               in0_qid,
  input  logic [DATA_WIDTH-1:0]                  in0_data,
  output logic                                   in0_ready,
  input  logic                                   in1_valid,
  input  logic [$clog2(NUM_Q)-1:0]               in1_qid,
  input  logic [DATA_WIDTH-1:0]                  in1_data,
  output logic                                   in1_ready,
  output logic [NUM_Q-1:0]                       q_wen1,
  output logic [NUM_Q-1:0]                       q_wen2,
  output logic [DATA_WIDTH-1:0]                  q_din1,
  output logic [DATA_WIDTH-1:0]                  q_din2,
  output logic [NUM_Q-1:0]                       q_ren,
  input  logic [NUM_Q*DATA_WIDTH-1:0]            q_dout,
  output logic                                   out_valid,
  output logic [$clog2(NUM_Q)-1:0]               out_qid,
  output logic [DATA_WIDTH-1:0]                  out_data,
  input  logic                                   out_ready,
  output logic [NUM_Q*($clog2(DEPTH)+1)-1:0]     q_count
);

  localparam int QW = $clog2(NUM_Q);
  localparam int CW = CNT_W(DEPTH);

  logic [CW-1:0]         cnt [NUM_Q];
  logic [CW-1:0]         cnt0_sel;
  logic [CW-1:0]         cnt1_sel;
  logic [CW:0]           cnt1_ahead;
  logic                  in0_fire;
  logic                  in1_fire;
  logic [NUM_Q-1:0]      eligible;
  logic [NUM_Q-1:0]      gnt;
  logic [QW-1:0]         gnt_idx;
  logic                  gnt_valid;
  logic [QW-1:0]         last;
  logic                  load;
  logic [DATA_WIDTH-1:0] head;
  out_state_e            state;

  // Readiness looks only at current occupancy; a pop on the same edge is
  // never credited, so a full queue stays closed for one extra cycle.
  assign cnt0_sel   = cnt[in0_qid];
  assign cnt1_sel   = cnt[in1_qid];
  // in1 must also account for an in0 push landing in the same queue.
  assign cnt1_ahead = {1'b0, cnt1_sel} + (CW+1)'(in0_fire && (in0_qid == in1_qid));

  assign in0_ready = !rst && (cnt0_sel < CW'(DEPTH));
  assign in1_ready = !rst && (cnt1_ahead < (CW+1)'(DEPTH));
  assign in0_fire  = in0_valid && in0_ready;
  assign in1_fire  = in1_valid && in1_ready;

  // in0 always uses slot 1 and in1 slot 2; on a shared queue the queue
  // writes slot 1 ahead of slot 2, which keeps port 0 older.
  always_comb begin
    q_wen1 = '0;
    q_wen2 = '0;
    if (in0_fire) q_wen1[in0_qid] = 1'b1;
    if (in1_fire) q_wen2[in1_qid] = 1'b1;
  end

  assign q_din1 = in0_data;
  assign q_din2 = in1_data;

  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      eligible[i] = (cnt[i] != '0);
    end
  end

  rr_arbiter #(
    .NUM_Q (NUM_Q),
    .QW    (QW)
  ) u_arb (
    .req       (eligible),
    .last      (last),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign out_valid = (state == FULL);
  assign load      = !out_valid || out_ready;
  assign q_ren     = load ? gnt : '0;
  assign head      = q_dout[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      q_count[i*CW +: CW] = cnt[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_Q; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_Q; i++) begin
        cnt[i] <= cnt[i] + CW'(q_wen1[i]) + CW'(q_wen2[i]) - CW'(q_ren[i]);
      end
    end
  end

  // Output register: loads whenever it is empty or being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_qid  <= '0;
      out_data <= '0;
      last     <= QW'(NUM_Q - 1);
    end else begin
      if (load && gnt_valid) begin
        out_qid  <= gnt_idx;
        out_data <= head;
`ifndef REQ_SCHED_STRICT_PRIO_EN
        last     <= gnt_idx;
`endif
      end
      case (state)
        EMPTY:   if (gnt_valid) state <= FULL;
        FULL:    if (out_ready && !gnt_valid) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/req_queue_scheduler.md
# req_queue_scheduler

Front-end controller for a bank of `NUM_Q` dual-write request queues. The queues hold entries written in order: two-slot write ports, one read port, combinational head output. The block has three jobs:
- Accept up to two requests per cycle, each tagged with a target queue, and steer them onto the queues' dual write enables.
- Track per-queue occupancy, because the queues expose no full flag, and back-pressure requesters.
- Drain the queues one entry per cycle into a single registered downstream port through a round-robin arbiter.

## Interface
- `NUM_Q`, 4, number of queues (≥2)
- `DATA_WIDTH`, 6, request payload width
- `DEPTH`, 8, entries per queue (power of two)
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `in0_valid` / `in1_valid`  in  1  request valid; port 0 is older
- `in0_qid` / `in1_qid`  in  $clog2(NUM_Q)  target queue
- `in0_data` / `in1_data`  in  DATA_WIDTH  payload
- `in0_ready` / `in1_ready`  out  1  request accepted when valid&&ready
- `q_wen1`  out  NUM_Q  per-queue first-slot write enable
- `q_wen2`  out  NUM_Q  per-queue second-slot write enable
- `q_din1` / `q_din2`  out  DATA_WIDTH  shared write data (= in0_data / in1_data)
- `q_ren`  out  NUM_Q  per-queue pop, one-hot or zero
- `q_dout`  in  NUM_Q*DATA_WIDTH  queue heads, queue i at [i*DATA_WIDTH +: DATA_WIDTH]
- `out_valid`  out  1  downstream valid
- `out_qid`  out  $clog2(NUM_Q)  source queue of out_data
- `out_data`  out  DATA_WIDTH  popped entry
- `out_ready`  in  1  downstream accept
- `q_count`  out  NUM_Q*($clog2(DEPTH)+1)  occupancy per queue

## Operation
- Occupancy `cnt[i]` is `$clog2(DEPTH)+1` bits, range 0..DEPTH.
- Update: `cnt[i] <= cnt[i] + wen1[i] + wen2[i] - ren[i]`, with the same-edge push and pop combined.
- Readiness:
  - `in0_ready = cnt[in0_qid] < DEPTH`. It does not depend on in0_valid.
  - `in1_ready = cnt[in1_qid] + (in0_fire && in0_qid==in1_qid) < DEPTH`.
  - A pop in the same cycle is never credited.
- Steering:
  - Both fire, same qid q: `q_wen1[q]=q_wen2[q]=1`. in0 lands first, in1 second.
  - Both fire, different qids a,b: `q_wen1[a]=1`, `q_wen2[b]=1`.
  - Only in1 fires to q: `q_wen2[q]=1` only. The queue writes din2 at its write pointer.
  - `q_din1/q_din2` are driven unconditionally.
- Arbiter:
  - Eligible set: `cnt[i]!=0`.
  - The arbiter runs when `load = !out_valid || out_ready`.
  - Round-robin search starts at `last+1` mod NUM_Q.
  - On a grant g: `q_ren[g]=1`, `out_data<=q_dout[g]`, `out_qid<=g`, `out_valid<=1`, `last<=g`.
  - If `load` and nothing is eligible: `out_valid<=0`, `q_ren=0`.
  - If `!load`, the output and `last` hold.
- Output register states: EMPTY (out_valid=0), FULL (out_valid=1).
  - EMPTY→FULL on grant.
  - FULL→FULL on out_ready with grant, or on !out_ready.
  - FULL→EMPTY on out_ready with no grant.

## Timing
- Reset values:
  - `cnt`=0, `out_valid`=0, `out_qid`=0, `out_data`=0, `last`=NUM_Q-1 (queue 0 wins first).
  - `q_ren`=0, `q_wen*`=0. Write enables follow the inputs, so they are 0 while reset holds and no readiness is granted.
- During reset, in*_ready are forced to 0. The queues are reset by the same event.
- Latency:
  - Request accepted in cycle N: written at edge N, eligible in N+1, out_valid in N+2 at the earliest.
  - Back-to-back out_ready=1 streams one entry per cycle.
- Boundaries:
  - cnt=DEPTH-1 with both ports to that queue: in0 accepted, in1 refused.
  - cnt=DEPTH with a pop the same cycle: push still refused.
  - Pop and push on the same queue at cnt=1: cnt stays 1 (or 2 if a dual push).
  - The arbiter never pops a queue with cnt=0. Pops are independent of any write in the same cycle.
- Reset mid-operation: all state clears immediately. An in-flight out_valid drops without a handshake.

## Configuration
- `REQ_SCHED_STRICT_PRIO_EN`:
  - Defined: fixed priority. The lowest-index eligible queue always wins, and `last` is unused (kept at reset value).
  - Undefined: the round-robin described above.

## Structure
- Package `req_sched_pkg`: `QID_W`, `CNT_W` localparam functions, and the `out_state_e` (EMPTY/FULL) typedef.
- Sub-module `rr_arbiter`: inputs NUM_Q request vector and `last`; outputs a one-hot grant and its index. It also contains the strict-priority variant under the macro.
- Occupancy counters, steering and the output register stay in the top module.

## Test plan
- Reset, then in0 to q2 with data 0x15, out_ready=1 → q_wen1[2] at cycle 0; out_valid=1, out_qid=2, out_data=0x15 at cycle 2; cnt[2] returns to 0.
- Both ports to q1 with 0x01/0x02 → q_wen1[1]=q_wen2[1]=1 same cycle; outputs 0x01 then 0x02 in order.
- Fill q0 to 7 entries, out_ready=0, both ports to q0 → in0_ready=1, in1_ready=0; cnt[0]=8, then all ready to q0 deasserted.
- One entry each in q0,q1,q3 with out_ready=1 → output order q0,q1,q3, then out_valid=0. Under `REQ_SCHED_STRICT_PRIO_EN`, continuous refill of q0 starves q3.
- out_ready held 0 for 5 cycles with out_valid=1 → out_data/out_qid stable, q_ren=0 throughout.
- Assert rst with 3 entries queued and out_valid=1 → next cycle out_valid=0, q_count all 0, both ready=0 while rst is high.
